// File: rtl/fpga_ram_port_ctrl.sv
// Initiator-side controller for a single-port write-first RAM with 1-cycle read latency:
// clears the RAM after reset, then maps a request stream to RAM cycles and buffers read data.
module fpga_ram_port_ctrl #(
    parameter int                   DATAWIDTH     = 64,
    parameter int                   ADDRWIDTH     = 10,
    parameter bit                   INIT_ON_RESET = 1'b1,
    parameter logic [DATAWIDTH-1:0] INIT_VALUE    = '0
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 ReqValid,
    output logic                 ReqReady,
    input  logic                 ReqWrite,
    input  logic [ADDRWIDTH-1:0] ReqAddr,
    input  logic [DATAWIDTH-1:0] ReqWData,
    output logic                 RspValid,
    input  logic                 RspReady,
    output logic [DATAWIDTH-1:0] RspRData,
    output logic                 InitDone,
    output logic [ADDRWIDTH-1:0] RamAddr,
    output logic [DATAWIDTH-1:0] RamDataIn,
    output logic                 RamWriteEnable,
    input  logic [DATAWIDTH-1:0] RamDataOut
);

    typedef enum logic {INIT, RUN} stateT;

    stateT                state, nextState;
    logic [ADDRWIDTH-1:0] initCount;
    logic                 initLast;
    logic                 rdInFlight;
    logic [DATAWIDTH-1:0] rspBuf [2];
    logic                 wrPtr, rdPtr;
    logic [1:0]           occupancy;
    logic [1:0]           loadAfterPop;
    logic                 readAccept, push, pop;

    assign initLast   = &initCount;
    assign InitDone   = (state == RUN);
    assign readAccept = ReqValid && ReqReady && !ReqWrite;
    assign push       = rdInFlight;
    assign pop        = RspValid && RspReady;
    assign RspValid   = (occupancy != 2'd0);
    assign RspRData   = rspBuf[rdPtr];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= INIT;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            INIT: if (!INIT_ON_RESET || initLast) nextState = RUN;
            RUN:  nextState = RUN;
        endcase
    end

    // A slot freed by this cycle's pop can be reused immediately, which keeps one read
    // per cycle flowing while the buffer plus the in-flight read still never exceed two.
    assign loadAfterPop = occupancy - {1'b0, pop} + {1'b0, rdInFlight};

    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        ReqReady       = 1'b0;
        RamAddr        = ReqAddr;
        RamDataIn      = ReqWData;
        RamWriteEnable = 1'b0;
        case (state)
            INIT: begin
                if (INIT_ON_RESET) begin
                    RamAddr        = initCount;
                    RamDataIn      = INIT_VALUE;
                    RamWriteEnable = !Reset;
                end
            end
            RUN: begin
                ReqReady       = !loadAfterPop[1];
                RamWriteEnable = ReqValid && ReqReady && ReqWrite;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            initCount  <= '0;
            rdInFlight <= 1'b0;
        end else begin
            if (state == INIT) initCount <= initCount + 1'b1;
            rdInFlight <= readAccept;
        end
    end

    // NOTE: the two buffer words are reset too, so RspRData reads 0 rather than X after reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rspBuf[0] <= '0;
            rspBuf[1] <= '0;
            wrPtr     <= 1'b0;
            rdPtr     <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            if (push) begin
                rspBuf[wrPtr] <= RamDataOut;
                wrPtr         <= !wrPtr;
            end
            if (pop) rdPtr <= !rdPtr;
            occupancy <= occupancy + {1'b0, push} - {1'b0, pop};
        end
    end

    bufferOverflow: assert property (@(posedge Clk) disable iff (Reset)
        !(push && !pop && occupancy == 2'd2));

endmodule

// File: tb/tb_fpga_ram_port_ctrl.sv
// Directed bench for fpga_ram_port_ctrl: one instance with clear-on-reset, one without,
// each attached to a behavioural write-first RAM.
module tb_fpga_ram_port_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1, Reset0 = 1'b1;
    logic        ReqValid = 1'b0, ReqWrite = 1'b0, RspReady = 1'b1;
    logic [3:0]  ReqAddr = '0;
    logic [15:0] ReqWData = '0;

    logic        ReqReady, RspValid, InitDone, RamWriteEnable;
    logic [15:0] RspRData, RamDataIn, RamDataOut;
    logic [3:0]  RamAddr;
    logic        ReqReady0, RspValid0, InitDone0, RamWriteEnable0;
    logic [15:0] RspRData0, RamDataIn0, RamDataOut0;
    logic [3:0]  RamAddr0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0] mem  [16];
    logic [15:0] mem0 [16];
    logic [15:0] rspQ[$];
    int          rspCycQ[$];
    logic [15:0] rsp0Q[$];

    fpga_ram_port_ctrl #(.DATAWIDTH(16), .ADDRWIDTH(4), .INIT_ON_RESET(1'b1), .INIT_VALUE(16'h00A5)) dut (
        .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
        .ReqAddr(ReqAddr), .ReqWData(ReqWData), .RspValid(RspValid), .RspReady(RspReady),
        .RspRData(RspRData), .InitDone(InitDone), .RamAddr(RamAddr), .RamDataIn(RamDataIn),
        .RamWriteEnable(RamWriteEnable), .RamDataOut(RamDataOut));

    fpga_ram_port_ctrl #(.DATAWIDTH(16), .ADDRWIDTH(4), .INIT_ON_RESET(1'b0), .INIT_VALUE(16'h00A5)) dut0 (
        .Clk(Clk), .Reset(Reset0), .ReqValid(ReqValid), .ReqReady(ReqReady0), .ReqWrite(ReqWrite),
        .ReqAddr(ReqAddr), .ReqWData(ReqWData), .RspValid(RspValid0), .RspReady(RspReady),
        .RspRData(RspRData0), .InitDone(InitDone0), .RamAddr(RamAddr0), .RamDataIn(RamDataIn0),
        .RamWriteEnable(RamWriteEnable0), .RamDataOut(RamDataOut0));

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Write-first RAMs with one cycle of read latency.
    always @(posedge Clk) begin
        if (RamWriteEnable) begin
            mem[RamAddr] <= RamDataIn;
            RamDataOut   <= RamDataIn;
        end else begin
            RamDataOut <= mem[RamAddr];
        end
        if (RamWriteEnable0) begin
            mem0[RamAddr0] <= RamDataIn0;
            RamDataOut0    <= RamDataIn0;
        end else begin
            RamDataOut0 <= mem0[RamAddr0];
        end
    end

    // Response monitor: inputs change at the falling edge, so +2 sees this cycle's handshake.
    always @(negedge Clk) begin
        #2;
        if (RspValid && RspReady) begin
            rspQ.push_back(RspRData);
            rspCycQ.push_back(cyc);
        end
        if (RspValid0 && RspReady) rsp0Q.push_back(RspRData0);
    end

    function automatic logic [15:0] rspAt(input int i);
        return (i < rspQ.size()) ? rspQ[i] : 16'hxxxx;
    endfunction

    function automatic int rspCycAt(input int i);
        return (i < rspCycQ.size()) ? rspCycQ[i] : -1;
    endfunction

    // Presents a request from the next falling edge and holds it until accepted by dut.
    task automatic issue(input logic wr, input logic [3:0] a, input logic [15:0] d, output int accCyc);
        int waited = 0;
        @(negedge Clk);
        ReqValid = 1'b1; ReqWrite = wr; ReqAddr = a; ReqWData = d;
        #1;
        while (!ReqReady && waited < 50) begin
            @(negedge Clk); #1;
            waited++;
        end
        if (!ReqReady) begin
            checks++; errors++;
            $display("FAIL issue_timeout addr=%0d ReqReady=%b required=1", a, ReqReady);
        end
        accCyc = cyc;
    endtask

    task automatic idle(input int n);
        @(negedge Clk);
        ReqValid = 1'b0;
        repeat (n - 1) @(negedge Clk);
    endtask

    // Releases dut from reset and follows the full 16-word clear.
    task automatic run_clear(input string tag);
        @(negedge Clk);
        Reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            #1;
            checks++;
            if (RamWriteEnable !== 1'b1 || RamAddr !== 4'(k) || RamDataIn !== 16'h00A5 ||
                ReqReady !== 1'b0 || InitDone !== 1'b0) begin
                errors++;
                $display("FAIL %s_clear_cycle%0d we=%b addr=%0d din=%h rdy=%b done=%b required we=1 addr=%0d din=00a5 rdy=0 done=0",
                         tag, k, RamWriteEnable, RamAddr, RamDataIn, ReqReady, InitDone, k);
            end
            @(negedge Clk);
        end
        #1;
        checks++;
        if (InitDone !== 1'b1 || ReqReady !== 1'b1 || RamWriteEnable !== 1'b0) begin
            errors++;
            $display("FAIL %s_init_done done=%b rdy=%b we=%b required done=1 rdy=1 we=0",
                     tag, InitDone, ReqReady, RamWriteEnable);
        end
        checks++;
        for (int i = 0; i < 16; i++) begin
            if (mem[i] !== 16'h00A5) begin
                errors++;
                $display("FAIL %s_ram_cleared addr=%0d got=%h required=00a5", tag, i, mem[i]);
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge Clk); #1;
        checks++;
        if (ReqReady !== 1'b0 || RspValid !== 1'b0 || RspRData !== 16'h0 || InitDone !== 1'b0 ||
            RamWriteEnable !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs rdy=%b rv=%b rd=%h done=%b we=%b required 0 0 0000 0 0",
                     ReqReady, RspValid, RspRData, InitDone, RamWriteEnable);
        end
        checks++;
        if (InitDone0 !== 1'b0 || RamWriteEnable0 !== 1'b0 || ReqReady0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs_noinit done=%b we=%b rdy=%b required 0 0 0",
                     InitDone0, RamWriteEnable0, ReqReady0);
        end
    endtask

    task automatic test_init_clear();
        int acc;
        run_clear("t1");
        rspQ.delete(); rspCycQ.delete();
        issue(1'b0, 4'd9, 16'h0, acc);
        idle(6);
        checks++;
        if (rspQ.size() !== 1 || rspAt(0) !== 16'h00A5) begin
            errors++;
            $display("FAIL t1_read_addr9 count=%0d data=%h required count=1 data=00a5", rspQ.size(), rspAt(0));
        end
    endtask

    task automatic test_write_read();
        int accW, accR;
        rspQ.delete(); rspCycQ.delete();
        issue(1'b1, 4'd3, 16'h1234, accW);
        checks++;
        if (RamWriteEnable !== 1'b1 || RamAddr !== 4'd3 || RamDataIn !== 16'h1234) begin
            errors++;
            $display("FAIL t2_write_drive we=%b addr=%0d din=%h required we=1 addr=3 din=1234",
                     RamWriteEnable, RamAddr, RamDataIn);
        end
        issue(1'b0, 4'd3, 16'h0, accR);
        checks++;
        if (accR !== accW + 1 || RamWriteEnable !== 1'b0) begin
            errors++;
            $display("FAIL t2_read_accept cycle=%0d we=%b required cycle=%0d we=0", accR, RamWriteEnable, accW + 1);
        end
        idle(8);
        checks++;
        if (rspQ.size() !== 1 || rspAt(0) !== 16'h1234 || rspCycAt(0) !== accR + 2) begin
            errors++;
            $display("FAIL t2_response count=%0d data=%h cycle=%0d required count=1 data=1234 cycle=%0d",
                     rspQ.size(), rspAt(0), rspCycAt(0), accR + 2);
        end
    endtask

    task automatic test_back_to_back();
        int acc, first;
        for (int i = 0; i < 8; i++) issue(1'b1, 4'(i), 16'h0100 + 16'(i), acc);
        rspQ.delete(); rspCycQ.delete();
        first = 0;
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, 4'(i), 16'h0, acc);
            if (i == 0) first = acc;
            checks++;
            if (acc !== first + i) begin
                errors++;
                $display("FAIL t3_accept_read%0d cycle=%0d required=%0d", i, acc, first + i);
            end
        end
        idle(10);
        checks++;
        if (rspQ.size() !== 8) begin
            errors++;
            $display("FAIL t3_response_count got=%0d required=8", rspQ.size());
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rspAt(i) !== 16'h0100 + 16'(i) || rspCycAt(i) !== first + 2 + i) begin
                errors++;
                $display("FAIL t3_response%0d data=%h cycle=%0d required data=%h cycle=%0d",
                         i, rspAt(i), rspCycAt(i), 16'h0100 + 16'(i), first + 2 + i);
            end
        end
    endtask

    task automatic test_backpressure();
        int accepted = 0;
        rspQ.delete(); rspCycQ.delete();
        RspReady = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge Clk);
            ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 4'(accepted);
            #1;
            if (ReqReady) accepted++;
        end
        checks++;
        if (accepted !== 2 || ReqReady !== 1'b0) begin
            errors++;
            $display("FAIL t4_stall accepted=%0d rdy=%b required accepted=2 rdy=0", accepted, ReqReady);
        end
        checks++;
        if (RspValid !== 1'b1 || RspRData !== 16'h0100) begin
            errors++;
            $display("FAIL t4_head rv=%b data=%h required rv=1 data=0100", RspValid, RspRData);
        end
        @(negedge Clk);
        ReqValid = 1'b0;
        RspReady = 1'b1;
        #1;
        checks++;
        if (ReqReady !== 1'b1) begin
            errors++;
            $display("FAIL t4_ready_return got=%b required=1", ReqReady);
        end
        idle(6);
        checks++;
        if (rspQ.size() !== 2 || rspAt(0) !== 16'h0100 || rspAt(1) !== 16'h0101) begin
            errors++;
            $display("FAIL t4_drain count=%0d d0=%h d1=%h required count=2 d0=0100 d1=0101",
                     rspQ.size(), rspAt(0), rspAt(1));
        end
    endtask

    task automatic test_reset_midop();
        int acc;
        rspQ.delete(); rspCycQ.delete();
        RspReady = 1'b0;
        issue(1'b0, 4'd5, 16'h0, acc);
        issue(1'b0, 4'd6, 16'h0, acc);
        @(negedge Clk);
        ReqValid = 1'b0;
        #1;
        checks++;
        if (RspValid !== 1'b1) begin
            errors++;
            $display("FAIL t5_buffered_before_reset rv=%b required=1", RspValid);
        end
        #2;
        Reset = 1'b1;
        #1;
        checks++;
        if (RspValid !== 1'b0 || InitDone !== 1'b0 || ReqReady !== 1'b0 || RamWriteEnable !== 1'b0) begin
            errors++;
            $display("FAIL t5_async_drop rv=%b done=%b rdy=%b we=%b required 0 0 0 0",
                     RspValid, InitDone, ReqReady, RamWriteEnable);
        end
        RspReady = 1'b1;
        repeat (3) @(negedge Clk);
        run_clear("t5");
        idle(4);
        checks++;
        if (rspQ.size() !== 0) begin
            errors++;
            $display("FAIL t5_stale_response count=%0d data=%h required count=0", rspQ.size(), rspAt(0));
        end
    endtask

    task automatic test_no_init();
        logic [15:0] refMem [16];
        logic [15:0] expQ[$];
        int idx = 0;
        @(negedge Clk);
        Reset0 = 1'b0;
        #1;
        checks++;
        if (InitDone0 !== 1'b0 || RamWriteEnable0 !== 1'b0) begin
            errors++;
            $display("FAIL t6_first_cycle done=%b we=%b required done=0 we=0", InitDone0, RamWriteEnable0);
        end
        @(negedge Clk); #1;
        checks++;
        if (InitDone0 !== 1'b1 || ReqReady0 !== 1'b1) begin
            errors++;
            $display("FAIL t6_init_done done=%b rdy=%b required done=1 rdy=1", InitDone0, ReqReady0);
        end
        RspReady = 1'b1;
        for (int c = 0; c < 40 && idx < 16; c++) begin
            @(negedge Clk);
            ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 4'(idx); ReqWData = 16'($urandom);
            #1;
            if (ReqReady0) begin
                refMem[idx] = ReqWData;
                idx++;
            end
        end
        rsp0Q.delete();
        for (int c = 0; c < 200; c++) begin
            @(negedge Clk);
            ReqValid = ($urandom_range(3) != 0);
            ReqWrite = ($urandom_range(2) == 0);
            ReqAddr  = 4'($urandom);
            ReqWData = 16'($urandom);
            RspReady = ($urandom_range(3) != 0);
            #1;
            checks++;
            if (RamWriteEnable0 !== (ReqValid && ReqReady0 && ReqWrite)) begin
                errors++;
                $display("FAIL t6_write_enable cycle=%0d got=%b required=%b", c, RamWriteEnable0,
                         ReqValid && ReqReady0 && ReqWrite);
            end
            if (ReqValid && ReqReady0) begin
                if (ReqWrite) refMem[ReqAddr] = ReqWData;
                else          expQ.push_back(refMem[ReqAddr]);
            end
        end
        @(negedge Clk);
        ReqValid = 1'b0;
        RspReady = 1'b1;
        repeat (6) @(negedge Clk);
        checks++;
        if (rsp0Q.size() !== expQ.size() || expQ.size() == 0) begin
            errors++;
            $display("FAIL t6_response_count got=%0d required=%0d (nonzero)", rsp0Q.size(), expQ.size());
        end
        for (int i = 0; i < expQ.size() && i < rsp0Q.size(); i++) begin
            checks++;
            if (rsp0Q[i] !== expQ[i]) begin
                errors++;
                $display("FAIL t6_response%0d got=%h required=%h", i, rsp0Q[i], expQ[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_init_clear();
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_reset_midop();
        @(negedge Clk);
        Reset = 1'b1;
        test_no_init();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time=%0t required finish before 1000000", $time);
        $fatal(1);
    end

endmodule
